// File: rtl/out_layer_mac_pkg.sv
// Shared definitions for the output-layer classifier: FSM states, sizes and
// the product-to-accumulator sign extension helper.
// Ports: none (package).
package out_layer_mac_pkg;

  localparam int N_TERMS   = 256;  // hidden activations per class
  localparam int N_CLASSES = 10;   // output digits 0..9
  localparam int W_DATA    = 8;    // signed weight / activation width
  localparam int W_ACC     = 24;   // 256 * 2^14 = 2^22, so 24 bits never overflow
  localparam int DRAIN_CYC = 2;    // cycles to empty the ROM + multiply stages

  localparam int W_PROD  = 2 * W_DATA;
  localparam int W_ADDR  = $clog2(N_TERMS);
  localparam int W_CLS   = 4;
  localparam int W_DRAIN = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  // Most negative accumulator value: any real class score beats it, so class 0
  // always becomes the first candidate.
  localparam logic signed [W_ACC-1:0] ACC_MIN = {1'b1, {(W_ACC-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic signed [W_ACC-1:0] sext_prod(input logic signed [W_PROD-1:0] p);
    return {{(W_ACC-W_PROD){p[W_PROD-1]}}, p};
  endfunction

endpackage

// File: rtl/out_layer_mac_mac_s8.sv
// Registered signed 8x8 multiplier with a valid bit carried alongside.
// Ports: clk, rst_n, in_vld, a, b -> prod (16-bit signed), out_vld.
// Latency 1 cycle; no backpressure, the product register only loads on in_vld.
module mac_s8
  import out_layer_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  input  logic signed [W_DATA-1:0] a,
  input  logic signed [W_DATA-1:0] b,
  output logic signed [W_PROD-1:0] prod,
  output logic                     out_vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod    <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      // Hold the product when idle to avoid needless toggling.
      if (in_vld) begin
        prod <= W_PROD'(a) * W_PROD'(b);
      end
    end
  end

endmodule

// File: rtl/out_layer_mac.sv
// Output-layer classifier: for each of 10 classes, accumulates 256 signed
// weight*activation products and keeps the arg-max class as the recognised digit.
// Ports: clk, rst_n, start; W10ra/w_data/h_data from the external W10 counter and
// memories; W10ra_rst/adv/cls drive them; busy, done, digit, best_score report.
// Latency: done exactly 2591 cycles after start is sampled (10 x 259 + 1).
module out_layer_mac
  import out_layer_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [W_ADDR-1:0]        W10ra,
  input  logic signed [W_DATA-1:0] w_data,
  input  logic signed [W_DATA-1:0] h_data,
  output logic                     W10ra_rst,
  output logic                     adv,
  output logic [W_CLS-1:0]         cls,
  output logic                     busy,
  output logic                     done,
  output logic [W_CLS-1:0]         digit,
  output logic signed [W_ACC-1:0]  best_score
);

  state_t state, nxt;

  logic [W_DRAIN-1:0]       drain_cnt;
  logic                     drain_last;
  logic                     cls_last;
  logic                     v1;
  logic                     v2;
  logic signed [W_PROD-1:0] prod;
  logic signed [W_ACC-1:0]  acc;
  // Running best over the classes done so far; the visible best_score/digit are
  // only loaded at the end so they stay stable for the whole classification.
  logic signed [W_ACC-1:0]  best_run;
  logic [W_CLS-1:0]         best_idx;
  logic                     acc_wins;

  assign drain_last = (drain_cnt == W_DRAIN'(DRAIN_CYC - 1));
  assign cls_last   = (cls == W_CLS'(N_CLASSES - 1));
  // Strictly greater: classes are visited in ascending order, so on a tie the
  // earlier (lower) index is kept.
  assign acc_wins   = (acc > best_run);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt       = state;
    adv       = 1'b0;
    W10ra_rst = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        W10ra_rst = 1'b1;
        busy      = 1'b0;
        if (start) begin
          nxt = RUN;
        end
      end
      RUN: begin
        adv = 1'b1;
        if (W10ra == W_ADDR'(N_TERMS - 1)) begin
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        // adv low lets the counter fall back to 0 for the next class while the
        // last terms work through the ROM and multiply stages.
        if (drain_last) begin
          nxt = CMP;
        end
      end
      CMP: begin
        nxt = cls_last ? DONE : RUN;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Multiply pipeline: address in RUN -> operands valid next cycle (v1) ->
  // registered product (v2) -> accumulate.
  // --------------------------------------------------------------------------
  mac_s8 u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (v1),
    .a       (w_data),
    .b       (h_data),
    .prod    (prod),
    .out_vld (v2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      drain_cnt <= '0;
      acc       <= '0;
      cls       <= '0;
      best_run  <= '0;
      best_idx  <= '0;
      digit     <= '0;
      best_score <= '0;
      done      <= 1'b0;
    end else begin
      v1        <= (state == RUN);
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      done      <= 1'b0;

      if (v2) begin
        acc <= acc + sext_prod(prod);
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            best_run <= ACC_MIN;
            best_idx <= '0;
            cls      <= '0;
          end
        end
        CMP: begin
          // The pipeline is empty here (v2 low), so clearing wins cleanly.
          acc <= '0;
          if (acc_wins) begin
            best_run <= acc;
            best_idx <= cls;
          end
          if (cls_last) begin
            // Fold in the last class directly so the result is visible
            // together with the done pulse.
            digit      <= acc_wins ? cls : best_idx;
            best_score <= acc_wins ? acc : best_run;
            done       <= 1'b1;
          end else begin
            cls <= cls + 1'b1;
          end
        end
        DONE: begin
          cls <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_layer_mac.sv
module tb_out_layer_mac;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        W10ra;
  logic signed [7:0] w_data;
  logic signed [7:0] h_data;
  logic              W10ra_rst;
  logic              adv;
  logic [3:0]        cls;
  logic              busy;
  logic              done;
  logic [3:0]        digit;
  logic signed [23:0] best_score;

  int total = 0;
  int bad   = 0;

  byte w_rom [0:15][0:255];
  byte h_mem [0:255];

  always #5 clk = ~clk;

  out_layer_mac dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .W10ra      (W10ra),
    .w_data     (w_data),
    .h_data     (h_data),
    .W10ra_rst  (W10ra_rst),
    .adv        (adv),
    .cls        (cls),
    .busy       (busy),
    .done       (done),
    .digit      (digit),
    .best_score (best_score)
  );

  // Environment: W10 read-address counter and the two synchronous memories.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                W10ra <= 8'd0;
    else if (W10ra_rst || !adv) W10ra <= 8'd0;
    else                       W10ra <= W10ra + 8'd1;
  end

  always @(posedge clk) begin
    w_data <= w_rom[cls][W10ra];
    h_data <= h_mem[W10ra];
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: dot product per class, arg-max with the lowest index on ties.
  task automatic model(output int d, output int b);
    int s;
    d = 0;
    b = -(1 << 23);
    for (int c = 0; c < 10; c++) begin
      s = 0;
      for (int i = 0; i < 256; i++) s += int'(w_rom[c][i]) * int'(h_mem[i]);
      if (s > b) begin
        b = s;
        d = c;
      end
    end
  endtask

  task automatic fill(input int wval, input int hval);
    for (int c = 0; c < 16; c++)
      for (int i = 0; i < 256; i++) w_rom[c][i] = byte'(wval);
    for (int i = 0; i < 256; i++) h_mem[i] = byte'(hval);
  endtask

  task automatic fill_random();
    for (int c = 0; c < 16; c++)
      for (int i = 0; i < 256; i++) w_rom[c][i] = byte'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) h_mem[i] = byte'($urandom_range(0, 255));
  endtask

  // One classification from start to done. pulse_at > 0 additionally pulses
  // start at that cycle (while busy) and in the DONE cycle.
  task automatic run_class(input string tag, input int pulse_at);
    int exp_d, exp_b, k, c, off, seq_err, n_done;
    logic [3:0] prev_d;
    logic signed [23:0] prev_b;
    bit seen;
    model(exp_d, exp_b);
    @(negedge clk);
    prev_d = digit;
    prev_b = best_score;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; seen = 0; seq_err = 0;
    while (!seen && k <= 2700) begin
      if (k <= 2590) begin
        c   = (k - 1) / 259;
        off = (k - 1) % 259;
        if (adv !== (off < 256)) seq_err++;
        if (cls !== c[3:0]) seq_err++;
        if (W10ra !== ((off < 256) ? off[7:0] : 8'd0)) seq_err++;
        if (busy !== 1'b1) seq_err++;
        if (digit !== prev_d || best_score !== prev_b) seq_err++;
      end
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        start = (k == pulse_at);
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      check({tag, "_latency"}, k, 2591);
      check({tag, "_seq"}, seq_err, 0);
      check({tag, "_digit"}, digit, exp_d);
      check({tag, "_best"}, best_score, exp_b);
      if (pulse_at > 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_clr"}, busy, 0);
      n_done = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (done === 1'b1 || busy !== 1'b0 || adv !== 1'b0) n_done++;
      end
      check({tag, "_stay_idle"}, n_done, 0);
      check({tag, "_digit_hold"}, digit, exp_d);
      check({tag, "_best_hold"}, best_score, exp_b);
    end
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0;
    start = 1'b0;
    fill(0, 0);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_adv", adv, 0);
    check("rst_w10ra_rst", W10ra_rst, 1);
    check("rst_cls", cls, 0);
    check("rst_digit", digit, 0);
    check("rst_best", best_score, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // All-zero weights: every class ties at 0, class 0 wins.
    fill(0, 0);
    for (int i = 0; i < 256; i++) h_mem[i] = byte'($urandom_range(0, 255));
    run_class("zero", 0);

    // Only class 7 has weight 1 with unit activations.
    fill(0, 1);
    for (int i = 0; i < 256; i++) w_rom[7][i] = 8'sd1;
    run_class("cls7", 0);

    // Extreme operands on class 3: 256 * 16384.
    fill(0, -128);
    for (int i = 0; i < 256; i++) w_rom[3][i] = -8'sd128;
    run_class("extreme", 0);

    // Tie between classes 4 and 8: lower index wins.
    fill(0, 1);
    for (int i = 0; i < 256; i++) begin
      w_rom[4][i] = 8'sd1;
      w_rom[8][i] = 8'sd1;
    end
    run_class("tie", 0);

    // Random weights and activations.
    fill_random();
    run_class("rand0", 0);
    fill_random();
    run_class("rand1", 0);

    // start pulsed while busy and in the DONE cycle: ignored.
    fill_random();
    run_class("busy_start", 700);

    // Reset in the middle of class 5 aborts with no done.
    fill_random();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int k = 1; k < 1 + 259 * 5 + 60; k++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("abort_cls_before", cls, 5);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_w10ra_rst", W10ra_rst, 1);
    check("abort_adv", adv, 0);
    check("abort_cls", cls, 0);
    check("abort_best", best_score, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (done === 1'b1 || busy !== 1'b0) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", n_done, 0);
    run_class("after_abort", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
